// File: rtl/serial_record_rx.sv
// UART 8N1 receiver that rebuilds multi-byte TDC records, MSB byte first.
// Latency: record_valid rises 1 cycle after new_byte for the last byte (3 cycles after the rx stop-bit midpoint, including the synchroniser).
// Backpressure: one-deep record buffer; a record completing while the buffer is held is dropped with overrun_err.
module serial_record_rx #(
  parameter int CLK_PER_BIT      = 12,
  parameter int BYTES_PER_RECORD = 6,
  parameter int GAP_TIMEOUT      = 1200
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [8*BYTES_PER_RECORD-1:0] record_data,
  output logic                          record_valid,
  input  logic                          record_ready,
  output logic [7:0]                    byte_data,
  output logic                          new_byte,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overrun_err,
  output logic [7:0]                    err_count,
  output logic                          busy
);

  localparam int REC_W = 8 * BYTES_PER_RECORD;
  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int IW    = (BYTES_PER_RECORD > 1) ? $clog2(BYTES_PER_RECORD) : 1;
  localparam int GW    = $clog2(GAP_TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTES_PER_RECORD - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Synchroniser and bit FSM state
  logic             r_rx_meta;
  logic             r_rx_sync;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shreg;
  logic             r_armed;

  // Record assembly state
  logic [IW-1:0]    r_byte_idx;
  logic [GW-1:0]    r_gap_cnt;
  logic [REC_W-1:0] r_rec_buf;
  logic             r_rec_done;

  // Registered outputs
  logic [7:0]       r_byte_data;
  logic             r_new_byte;
  logic             r_frame_err;
  logic             r_timeout_err;
  logic             r_overrun_err;
  logic [REC_W-1:0] r_rec_data;
  logic             r_rec_valid;
  logic [7:0]       r_err_count;

  logic [1:0]       w_err_inc;
  logic [8:0]       w_err_sum;

  // Two-flop synchroniser; presets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Bit FSM, byte assembly into the record buffer, and inter-byte gap timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shreg       <= '0;
      r_armed       <= 1'b0;
      r_byte_idx    <= '0;
      r_gap_cnt     <= '0;
      r_rec_buf     <= '0;
      r_rec_done    <= 1'b0;
      r_byte_data   <= '0;
      r_new_byte    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_new_byte    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rec_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // After a break the line must return high before a new start bit counts
          if (r_rx_sync) begin
            r_armed <= 1'b1;
          end
          if (r_armed && !r_rx_sync) begin
            r_state   <= ST_START;
            r_cnt     <= CNT_HALF;
            r_gap_cnt <= '0;
          end else if (r_byte_idx != '0) begin
            if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt     <= '0;
              r_byte_idx    <= '0;
              r_timeout_err <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_ONE;
            end
          end else begin
            r_gap_cnt <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == '0) begin
            if (!r_rx_sync) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
              r_cnt     <= CNT_FULL;
            end else begin
              // Start bit gone by mid-bit: treat as a glitch
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (r_cnt == '0) begin
            r_shreg <= {r_rx_sync, r_shreg[7:1]};
            r_cnt   <= CNT_FULL;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_STOP: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            if (r_rx_sync) begin
              r_byte_data <= r_shreg;
              r_new_byte  <= 1'b1;
              for (int k = 0; k < BYTES_PER_RECORD; k++) begin
                if (r_byte_idx == IW'(k)) begin
                  r_rec_buf[REC_W-1-8*k -: 8] <= r_shreg;
                end
              end
              if (r_byte_idx == IDX_LAST) begin
                r_byte_idx <= '0;
                r_rec_done <= 1'b1;
              end else begin
                r_byte_idx <= r_byte_idx + IDX_ONE;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_byte_idx  <= '0;
              r_armed     <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-deep output buffer: a fresh record may replace one consumed this same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rec_data    <= '0;
      r_rec_valid   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_overrun_err <= 1'b0;
      if (r_rec_done) begin
        if (!r_rec_valid || record_ready) begin
          r_rec_data  <= r_rec_buf;
          r_rec_valid <= 1'b1;
        end else begin
          r_overrun_err <= 1'b1;
        end
      end else if (r_rec_valid && record_ready) begin
        r_rec_valid <= 1'b0;
      end
    end
  end

  assign w_err_inc = {1'b0, r_frame_err} + {1'b0, r_timeout_err} + {1'b0, r_overrun_err};
  assign w_err_sum = {1'b0, r_err_count} + {7'd0, w_err_inc};

  // Saturating error counter; coincident strobes each count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else begin
      r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
    end
  end

  assign record_data  = r_rec_data;
  assign record_valid = r_rec_valid;
  assign byte_data    = r_byte_data;
  assign new_byte     = r_new_byte;
  assign frame_err    = r_frame_err;
  assign timeout_err  = r_timeout_err;
  assign overrun_err  = r_overrun_err;
  assign err_count    = r_err_count;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: doc/serial_record_rx.md
Name: serial_record_rx

Overview:
- UART receiver that is the far end of the TDC serial output link. It reassembles the 8N1 byte stream carrying 48-bit TDC records (6 bytes, MSB byte first) back into records.
- Used for on-board loopback of SERIAL_OUT_TDC and on a companion Mojo that consumes TDC data.
- Presents each record through a one-deep valid/ready output buffer, plus per-byte strobes and error flags.

Parameters:
- CLK_PER_BIT, 12, clk cycles per UART bit (50 MHz / 4 Mbaud, truncated); minimum 4.
- BYTES_PER_RECORD, 6, bytes per record; record width is 8*BYTES_PER_RECORD.
- GAP_TIMEOUT, 1200, idle clk cycles allowed between bytes of one record before the partial record is discarded.

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rx  in  1  serial line, idle high, asynchronous to clk.
- record_data  out  48  last completed record; byte 0 received lands in [47:40].
- record_valid  out  1  record_data holds an unconsumed record.
- record_ready  in  1  consumer accepts; a transfer occurs when valid && ready.
- byte_data  out  8  last received byte.
- new_byte  out  1  one-cycle strobe when a byte with a valid stop bit completes.
- frame_err  out  1  one-cycle strobe on a bad stop bit.
- timeout_err  out  1  one-cycle strobe when a partial record is dropped on gap timeout.
- overrun_err  out  1  one-cycle strobe when a completed record is dropped because the buffer is full.
- err_count  out  8  saturating count of all error strobes.
- busy  out  1  high when the bit FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0 and record_data 0. Bit FSM goes to IDLE, byte index 0, gap counter 0, synchroniser flops preset to 1.
- rx passes through a 2-FF synchroniser. All bit logic uses the synchronised value, which is 2 cycles late.
- Bit FSM, states IDLE, START, DATA, STOP:
  - IDLE: a synchronised rx of 0 goes to START and loads bit counter = CLK_PER_BIT/2 - 1.
  - START: at count 0, sample rx. If 0, go to DATA with bit index 0 and counter = CLK_PER_BIT-1. If 1, it was a glitch: return to IDLE with no strobe.
  - DATA: sample at each count 0 and shift in LSB first. After bit 7, go to STOP with counter = CLK_PER_BIT-1.
  - STOP: sample at count 0.
    - rx=1: byte_data updates and new_byte pulses in the same cycle. FSM returns to IDLE.
    - rx=0: frame_err pulses, the byte is discarded and the byte index resets to 0. FSM goes to IDLE, which waits for rx high before re-arming (no false start on a break).
- Record assembly:
  - Each good byte is written into the shift buffer at position byte index, then the index increments.
  - On the BYTES_PER_RECORD-th byte, the index wraps to 0 and the record completes in the same cycle as new_byte.
  - If record_valid is 0, or record_ready is 1 that cycle, record_data loads and record_valid=1 on the next edge (latency: 1 cycle after the last stop-bit sample).
  - Otherwise overrun_err pulses, the new record is dropped and the held record is unchanged.
- Handshake:
  - record_valid clears on the edge after valid && ready unless a new record loads the same cycle; that case counts as a simultaneous load and valid stays 1.
  - record_data is stable while valid=1.
- Gap timeout:
  - The gap counter runs only while byte index ≠ 0 and the FSM is in IDLE; it clears on every falling-edge detect.
  - Reaching GAP_TIMEOUT sets byte index to 0 and pulses timeout_err. It does not fire when byte index = 0.
- err_count: increments by 1 for each frame/timeout/overrun strobe and saturates at 255. Two strobes in the same cycle count as 2, saturating.
- Reset mid-byte or mid-record discards everything; there is no partial output.

Test Plan:
- CLK_PER_BIT=12: send 0x01,0x02,0x03,0x04,0x05,0x06 back to back with ready=1 -> 6 new_byte strobes, then record_data=48'h010203040506 with valid for exactly 1 cycle, err_count=0.
- 1-cycle-to-5-cycle low glitches on idle rx -> no new_byte, no errors, busy returns low within CLK_PER_BIT/2+2 cycles.
- Byte 0xA5 sent with stop bit forced low -> frame_err pulse, err_count=1, no new_byte. Then a good 6-byte record of 0x11..0x66 -> record 48'h112233445566.
- 3 bytes, then a 2000-cycle idle gap, then 6 bytes 0xF0..0xF5 -> timeout_err once, record_data=48'hF0F1F2F3F4F5.
- ready=0, send two full records R1 and R2 -> overrun_err on R2's last byte, record_data=R1. Raise ready -> valid drops next cycle.
- Drop rst_n after 4 bytes, release, send 6 bytes -> only one record output, equal to the post-reset bytes. Also force 300 framing errors -> err_count holds 255.
